// File: rtl/fir_mac_pipe_if.sv
// Sample/result bundle for fir_mac_pipe: operands with frame markers in, accumulator and rounded result out.
interface fir_mac_pipe_if #(
    parameter int AW    = 18,
    parameter int BW    = 36,
    parameter int GUARD = 14,
    parameter int OUT_W = 24
);
    localparam int ACC_W = AW + BW + GUARD;

    logic                    in_valid;
    logic signed [AW-1:0]    in_a;
    logic signed [BW-1:0]    in_b;
    logic                    in_first;
    logic                    in_last;
    logic signed [ACC_W-1:0] acc_out;
    logic signed [OUT_W-1:0] res_out;
    logic                    res_valid;
    logic                    ovf;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last,
        input  acc_out, res_out, res_valid, ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last,
        output acc_out, res_out, res_valid, ovf
    );
endinterface

// File: rtl/fir_mac_pipe.sv
// Pipelined signed MAC with framed accumulation, half-up rounded result and sticky overflow.
// Define FIR_MAC_SAT_EN to saturate the shifted result to OUT_W bits; otherwise it wraps.
module fir_mac_pipe #(
    parameter int AW         = 18,
    parameter int BW         = 36,
    parameter int GUARD      = 14,
    parameter int MUL_STAGES = 2,
    parameter int OUT_W      = 24,
    parameter int SHIFT      = 16
) (
    input logic           clock,
    input logic           reset,
    fir_mac_pipe_if.slave bus
);
    localparam int PW    = AW + BW;
    localparam int ACC_W = PW + GUARD;
    localparam int SW    = ACC_W + 1;
    localparam int RW    = (SW > OUT_W + 1) ? SW : OUT_W + 1;
    // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
    localparam logic [SW-1:0] RND = (SW'(1) << SHIFT) >> 1;

    logic signed [AW-1:0]    a_q;
    logic signed [BW-1:0]    b_q;
    logic                    v_q;
    logic                    f_q;
    logic                    l_q;
    logic signed [PW-1:0]    prod;

    logic signed [PW-1:0]    p_pipe  [MUL_STAGES];
    logic                    pv_pipe [MUL_STAGES];
    logic                    pf_pipe [MUL_STAGES];
    logic                    pl_pipe [MUL_STAGES];

    logic                    pv;
    logic                    pf;
    logic                    pl;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic                    add_ovf;
    logic                    ovf_q;
    logic                    ovf_next;

    logic signed [SW-1:0]    rnd_q;
    logic                    rnd_v;
    logic signed [SW-1:0]    shifted;
    logic [OUT_W-1:0]        reduced;
    logic [OUT_W-1:0]        res_q;
    logic                    res_v_q;

    assign prod = PW'(a_q) * PW'(b_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                p_pipe[i]  <= '0;
                pv_pipe[i] <= 1'b0;
                pf_pipe[i] <= 1'b0;
                pl_pipe[i] <= 1'b0;
            end
        end else begin
            v_q <= bus.in_valid;
            f_q <= bus.in_valid & bus.in_first;
            l_q <= bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            p_pipe[0]  <= prod;
            pv_pipe[0] <= v_q;
            pf_pipe[0] <= f_q;
            pl_pipe[0] <= l_q;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                p_pipe[i]  <= p_pipe[i-1];
                pv_pipe[i] <= pv_pipe[i-1];
                pf_pipe[i] <= pf_pipe[i-1];
                pl_pipe[i] <= pl_pipe[i-1];
            end
        end
    end

    assign pv    = pv_pipe[MUL_STAGES-1];
    assign pf    = pf_pipe[MUL_STAGES-1];
    assign pl    = pl_pipe[MUL_STAGES-1];
    assign p_ext = ACC_W'(p_pipe[MUL_STAGES-1]);

    // A first product reloads the accumulator, so it can neither overflow nor inherit ovf.
    always_comb begin
        sum      = acc_q + p_ext;
        add_ovf  = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_next = pf ? p_ext : sum;
        ovf_next = pf ? 1'b0 : (ovf_q | add_ovf);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rnd_q   <= '0;
            rnd_v   <= 1'b0;
            res_q   <= '0;
            res_v_q <= 1'b0;
        end else begin
            if (pv) begin
                acc_q <= acc_next;
                ovf_q <= ovf_next;
            end
            rnd_v <= pv & pl;
            if (pv & pl) begin
                rnd_q <= SW'(acc_next) + signed'(RND);
            end
            res_v_q <= rnd_v;
            if (rnd_v) begin
                res_q <= reduced;
            end
        end
    end

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX = signed'((RW'(1) << (OUT_W - 1)) - RW'(1));
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [RW-1:0] ext;

    always_comb begin
        shifted = rnd_q >>> SHIFT;
        ext     = RW'(shifted);
        if (ext > SAT_MAX) begin
            reduced = SAT_MAX[OUT_W-1:0];
        end else if (ext < SAT_MIN) begin
            reduced = SAT_MIN[OUT_W-1:0];
        end else begin
            reduced = ext[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        shifted = rnd_q >>> SHIFT;
        reduced = OUT_W'(shifted);
    end
`endif

    assign bus.acc_out   = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.res_out   = res_q;
    assign bus.res_valid = res_v_q;
endmodule

// File: doc/fir_mac_pipe.md
# fir_mac_pipe

Parametrised, pipelined signed multiply-accumulate engine for the FIR datapath. It is the successor to the fixed 18x36 MAC: operand, guard and output widths are generic, and multiplier depth is configurable. It adds framed accumulation with `in_first`/`in_last`, a registered rounded output word with a valid pulse, and a sticky overflow flag. It sits between the coefficient/sample fetch logic and the output sample FIFO.

## Interface
- `AW`, default 18: signed width of operand A (sample).
- `BW`, default 36: signed width of operand B (coefficient).
- `GUARD`, default 14: accumulator guard bits. `ACC_W = AW+BW+GUARD`, which is 68 by default.
- `MUL_STAGES`, default 2: registered multiplier stages. Must be ≥1; the first stage is the input register.
- `OUT_W`, default 24: width of the rounded result.
- `SHIFT`, default 16: right shift applied to the accumulator before `res_out`. Must be ≥0.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: the sample on `in_a`/`in_b` is consumed at this edge.
- `in_a` in AW: signed operand A.
- `in_b` in BW: signed operand B.
- `in_first` in 1: sample starts a frame; the accumulator loads the product instead of adding it.
- `in_last` in 1: sample ends a frame; the result is emitted.
- `acc_out` out ACC_W: running signed accumulator.
- `res_out` out OUT_W: rounded frame result, held until the next frame result.
- `res_valid` out 1: one-cycle pulse when `res_out` updates.
- `ovf` out 1: sticky signed overflow of the accumulator within the current frame.

## Operation
- **Reset values:** on `reset`, `acc_out=0`, `res_out=0`, `res_valid=0`, `ovf=0`, and all pipeline valid bits are cleared.
- **Multiplier path:**
  - Full-precision signed product, `AW+BW` bits, sign-extended to ACC_W.
  - `in_first` and `in_last` travel alongside the product through the pipeline.
- **Accumulate stage:** when a valid product arrives:
  - `acc_next = first ? p : acc + p`.
  - Signed overflow of the ACC_W add sets `ovf`.
  - `first` clears `ovf` before that evaluation.
  - A product with `first` never overflows.
- **Bubbles:** a product slot with no valid sample leaves `acc_out` and `ovf` unchanged. `in_first`/`in_last` are ignored when `in_valid=0`.
- **Result stage:** on the accumulate of a `last` product, `acc_next` is captured.
  - Round half-up: add `1<<(SHIFT-1)` when SHIFT>0, then arithmetic shift right by SHIFT.
  - Reduce to OUT_W per Configuration.
  - Register into `res_out` and pulse `res_valid`.
- **Single-sample frame:** `first` and `last` on the same sample give result = product.
- **Back-to-back frames:** `last` on sample n and `first` on sample n+1, with `in_valid` continuous, need no bubble; results are independent.
- **Missing `first`:** a frame without `first` continues from the previous accumulator value. This is legal, and is used to split long filters.
- **Reset mid-frame:** all partial products are discarded. No `res_valid` is produced for samples in flight.

## Timing
- Sample taken at edge k.
- `acc_out` reflects it after edge `k+MUL_STAGES+1`.
- If the sample has `last`:
  - `res_valid` is high for exactly the cycle after edge `k+MUL_STAGES+2`.
  - `res_out` is stable from that edge on.
- Throughput: one sample per clock. There is no backpressure; `in_valid` may be high every cycle.
- `ovf` updates on the same edge as `acc_out`.

## Configuration
- `FIR_MAC_SAT_EN` defined: the shifted value saturates to `[-2^(OUT_W-1), 2^(OUT_W-1)-1]`.
- `FIR_MAC_SAT_EN` undefined: the shifted value is truncated to its low OUT_W bits (two's-complement wrap).
- Everything else is identical in both builds.

## Test plan
- **Frame sum:** defaults, frame (2,3),(-4,5),(7,-1) with `first` on sample 1 and `last` on sample 3 → `acc_out=-21`, one `res_valid` pulse at edge k3+4, `res_out=0`.
- **Rounding:** defaults, single-sample frames (16384,4) and then (16384,2) → `res_out=1` and `res_out=1`; `(-16384,2)` → `res_out=0`.
- **Output reduction:** defaults, single-sample frame `(-131072, -2^35)`, product `2^52`:
  - with `FIR_MAC_SAT_EN` → `res_out=8388607`;
  - without → `res_out=0`.
- **Bubbles and back-to-back frames:**
  - Frame A = (1,1),(1,1) with `in_valid` gaps of 3 cycles → `res_out=2`, `acc_out` constant during gaps.
  - Frame B = (5,5), starting the cycle after A's `last` → `res_out=25`, 1 cycle after A's result.
- **Overflow:** AW=4, BW=4, GUARD=1, SHIFT=0, OUT_W=9; four samples (-8,-8) with `first`/`last` → `ovf=1` at the 4th accumulate; the next frame (1,1) with `first`/`last` → `ovf=0`, `res_out=1`.
- **Reset mid-frame:** assert `reset` for 1 cycle after 2 of 5 samples → all outputs 0, no `res_valid`; a following frame (3,3) → `res_out=9`.
